// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
//   Burst controller in front of a single-port RAM. It takes one command at a
//   time (direction, base address, word count minus one). Write bursts stream
//   client words into consecutive RAM locations. Read bursts fetch consecutive
//   words and return them on a registered valid/ready stream.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   cmd_*               command handshake (cmd_ready only in IDLE)
//   wr_data/valid/ready write word stream (accepted when wr_valid & wr_ready)
//   rd_data/valid/ready read word stream (rd_data/rd_valid registered)
//   ram_in/addr/en/we   drive to the RAM; ram_out is the RAM read data
//   busy                high in every state except IDLE
//   done                one-cycle pulse when a burst completes
module ram_burst_ctrl #(
    parameter int DW = 8,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW-1:0] cmd_len,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] ram_in,
    output logic [AW-1:0] ram_addr,
    output logic          ram_en,
    output logic          ram_we,
    input  logic [DW-1:0] ram_out,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WRITE    = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_WAIT  = 3'd3;
    localparam logic [2:0] S_RD_OUT   = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]    r_state;
    logic [AW-1:0] r_cur_addr;
    logic [AW-1:0] r_cnt;
    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;
    logic [AW-1:0] r_last_addr;
    logic [DW-1:0] r_last_in;

    logic w_wr_fire;
    logic w_rd_issue;

    // RAM strobes are qualified with rst so that an edge with reset asserted
    // never touches the RAM, even if the FSM was mid-burst.
    assign w_wr_fire  = rst && (r_state == S_WRITE) && wr_valid;
    assign w_rd_issue = rst && (r_state == S_RD_ISSUE);

    assign ram_en   = w_wr_fire | w_rd_issue;
    assign ram_we   = w_wr_fire;
    // Address and data hold their last driven value while the RAM is idle.
    assign ram_addr = ram_en    ? r_cur_addr : r_last_addr;
    assign ram_in   = w_wr_fire ? wr_data    : r_last_in;

    assign cmd_ready = rst && (r_state == S_IDLE);
    assign wr_ready  = rst && (r_state == S_WRITE);
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_cnt       <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_last_addr <= '0;
            r_last_in   <= '0;
        end else begin
            if (ram_en) r_last_addr <= ram_addr;
            if (ram_we) r_last_in   <= ram_in;

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cur_addr <= cmd_addr;
                        r_cnt      <= cmd_len;
                        r_state    <= cmd_we ? S_WRITE : S_RD_ISSUE;
                    end
                end
                S_WRITE: begin
                    if (wr_valid) begin
                        if (r_cnt == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cur_addr <= r_cur_addr + 1'b1;
                            r_cnt      <= r_cnt - 1'b1;
                        end
                    end
                end
                S_RD_ISSUE: r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    // RAM data is valid in the cycle after the issue edge.
                    r_rd_data  <= ram_out;
                    r_rd_valid <= 1'b1;
                    r_state    <= S_RD_OUT;
                end
                S_RD_OUT: begin
                    if (rd_ready) begin
                        r_rd_valid <= 1'b0;
                        if (r_cnt == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cur_addr <= r_cur_addr + 1'b1;
                            r_cnt      <= r_cnt - 1'b1;
                            r_state    <= S_RD_ISSUE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Burst access controller that drives the single-port RAM interface (`in`, `addr`, `en`, `we`, `out`) on behalf of a client. It accepts a burst command: direction, base address and word count. For writes it streams client data into consecutive RAM words. For reads it fetches consecutive words and returns them over a valid/ready stream. It sits between client logic and the `ram` block, one command at a time.

Parameters:
DW, 8, data word width (matches RAM data width)
AW, 7, address width (matches RAM depth 2^AW)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset (0 = reset)
cmd_valid  input  1  command offered
cmd_ready  output  1  controller can accept a command (1 only in IDLE)
cmd_we  input  1  1 = write burst, 0 = read burst
cmd_addr  input  AW  burst base address
cmd_len  input  AW  burst word count minus 1 (0 = 1 word, 2^AW-1 = full RAM)
wr_data  input  DW  write data word
wr_valid  input  1  write word offered
wr_ready  output  1  write word accepted this cycle when wr_valid=1
rd_data  output  DW  read data word, registered
rd_valid  output  1  rd_data valid, registered
rd_ready  input  1  client consumes rd_data
ram_in  output  DW  to RAM `in`
ram_addr  output  AW  to RAM `addr`
ram_en  output  1  to RAM `en`
ram_we  output  1  to RAM `we`
ram_out  input  DW  from RAM `out`
busy  output  1  1 in any state except IDLE
done  output  1  one-cycle pulse at burst completion

Behaviour:
- RAM contract:
  - A write occurs at the clk edge where en=1 and we=1.
  - A read with en=1 and we=0 at edge N presents data on `ram_out` after edge N, stable through the next cycle.
- Reset (rst=0 at an edge):
  - State goes to IDLE; the address and count registers clear.
  - Outputs: rd_data=0, rd_valid=0, done=0, busy=0.
  - RAM drive: ram_en=0, ram_we=0, ram_addr=0, ram_in=0.
  - cmd_ready=1 from the first cycle after rst returns to 1.
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_OUT, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid=1: latch cur_addr=cmd_addr and cnt=cmd_len.
  - Next state is WRITE if cmd_we=1, else RD_ISSUE.
  - wr_valid and rd_ready are ignored in IDLE.
- WRITE:
  - wr_ready=1.
  - When wr_valid=1, drive combinationally: ram_en=1, ram_we=1, ram_addr=cur_addr, ram_in=wr_data. The word is written at that edge.
  - Then if cnt=0, go to DONE; else cur_addr+1, cnt-1.
  - When wr_valid=0: ram_en=0 and no state change.
- RD_ISSUE: ram_en=1, ram_we=0, ram_addr=cur_addr; next state RD_WAIT.
- RD_WAIT: ram_en=0; rd_data<=ram_out and rd_valid<=1 at the edge; next state RD_OUT.
- RD_OUT:
  - rd_valid=1 and rd_data held stable until rd_ready=1.
  - On handshake, rd_valid<=0. Then if cnt=0, go to DONE; else cur_addr+1, cnt-1, go to RD_ISSUE.
  - ram_en=0 throughout, including stalls.
- DONE: done=1 for exactly one cycle; next state IDLE.
- busy=1 in every state except IDLE.
- Read timing:
  - A command accepted at edge E gives RD_ISSUE in cycle E+1 and first rd_valid=1 in cycle E+3.
  - With rd_ready held 1, consecutive words arrive every 3 cycles.
- Write timing:
  - Maximum throughput is 1 word/cycle.
  - done pulses the cycle after the last accepted write.
- Arithmetic:
  - cur_addr increments modulo 2^AW, so a burst wraps from 2^AW-1 to 0.
  - cnt is AW bits; bursts of length 2^AW are legal.
- RAM drive in idle cycles: whenever ram_en=0, ram_we=0. ram_addr and ram_in hold their last value.
- Commands while busy are not accepted (cmd_ready=0). The client holds cmd_valid until accepted.
- Reset mid-burst:
  - The burst aborts at that edge with no further RAM access.
  - rd_valid drops and done is not pulsed.
  - Already-written words remain in RAM.

Test Plan:
1. Reset: rst=0 for 2 cycles with cmd_valid=1 -> no command accepted; rd_valid=0, ram_en=0, busy=0, done=0; cmd_ready=1 after rst=1.
2. Write burst: cmd_we=1, cmd_addr=2, cmd_len=2, wr_data 55,14,42 with wr_valid held 1 -> RAM written at addr 2=55, 3=14, 4=42 on three consecutive edges; done pulses once the next cycle; busy returns to 0.
3. Read burst: cmd_we=0, cmd_addr=2, cmd_len=2, rd_ready=1 -> rd_data 55,14,42 in order; first rd_valid 3 cycles after command accept, then every 3 cycles; done after the third handshake.
4. Backpressure: same read with rd_ready=0 for 5 cycles while rd_data=14 -> rd_valid and rd_data=14 held stable; ram_en=0 for all stall cycles; 42 returned after release.
5. Wrap-around: write cmd_addr=126, cmd_len=3, data 1,2,3,4 -> writes at 126,127,0,1. A subsequent read of the same burst returns 1,2,3,4.
6. Reset mid-read and mid-write: rst=0 during RD_OUT of word 2 -> rd_valid=0 next cycle, no done, no further ram_en. rst=0 after 1 of 3 writes -> only the first word changed in RAM.
